div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

- Initiator-side controller for the iterative divider.
- Sits between the EX stage and the divider.
- Captures a RV32M divide/remainder instruction presented by EX, stalls the pipeline, and drives and holds the divider start handshake. It consumes the divider's one-cycle ready pulse and emits a one-cycle register writeback.
- Also aborts an in-flight division on pipeline flush.

## Interface
Parameters:
- none (operand width fixed at 32, register address width 5 via `RegAddrBus`)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_i  in  1  EX holds a valid DIV/DIVU/REM/REMU instruction
- op_i  in  3  funct3: DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111
- rs1_i  in  32  dividend
- rs2_i  in  32  divisor
- rd_i  in  5  destination register
- flush_i  in  1  kill current instruction (jump/interrupt)
- stall_o  out  1  hold pipeline at EX
- div_start_o  out  1  divider start, level, held for whole operation
- div_op_o  out  3  latched op
- div_dividend_o  out  32  latched rs1
- div_divisor_o  out  32  latched rs2
- div_waddr_o  out  5  latched rd
- div_result_i  in  32  divider result
- div_ready_i  in  1  divider one-cycle done pulse
- div_busy_i  in  1  divider busy
- div_waddr_i  in  5  rd echoed by divider
- wb_we_o  out  1  writeback enable, one-cycle pulse
- wb_waddr_o  out  5  writeback register
- wb_wdata_o  out  32  writeback data

## Operation
States:
- IDLE
- BUSY
- DONE

Transitions:
- IDLE, req_i=1, flush_i=0, div_busy_i=0: latch op/rs1/rs2/rd, go BUSY.
- IDLE, req_i=1 with div_busy_i=1: stay IDLE, stall.
- BUSY, div_ready_i=1, flush_i=0: register wb_we_o=1, wb_wdata_o=div_result_i, wb_waddr_o=div_waddr_i; go DONE.
- BUSY, flush_i=1: go IDLE, no writeback.
  - flush_i wins over a simultaneous div_ready_i; the result is discarded.
- DONE: wb outputs valid this cycle; req_i ignored (it is the same, now-retiring instruction); go IDLE. flush_i in DONE does not cancel the write.

Outputs:
- stall_o = (IDLE & req_i & ~flush_i) | BUSY. DONE releases the stall.
- div_start_o = BUSY & ~div_ready_i & ~flush_i.
  - Combinational, so start is already low in the cycle ready is seen or flush arrives.
  - This prevents the divider from restarting from its idle state on the following edge.
- div_op_o/div_dividend_o/div_divisor_o/div_waddr_o: latched values. Constant for the whole BUSY period.
- Arithmetic (sign handling, negation) is entirely in the divider; this block passes operands unmodified.
- Reset: asynchronous and active-low. All registers, including the latched values, clear to 0 and the state to IDLE immediately, mid-operation included.
  - This drops div_start_o, which aborts the divider.

## Timing
- Request in cycle 0 → state BUSY and div_start_o=1 from cycle 1.
- div_ready_i in cycle N → wb_we_o=1 in cycle N+1 (DONE) → IDLE in cycle N+2.
- This block is latency-agnostic. Divider latency is roughly:
  - normal: 35 cycles from start rise;
  - divisor zero: 2 cycles from start rise.
- Back-to-back divides:
  - the second instruction reaches EX in cycle N+2 and is accepted in IDLE;
  - its start rises in cycle N+3.
- After a flush:
  - the divider sees start low and returns idle at the next edge;
  - a new request is accepted as soon as div_busy_i=0.
- wb_we_o is exactly one cycle wide. wb_waddr_o/wb_wdata_o hold their values until the next write.

## Configuration
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a request with rs2_i==0 goes directly to DONE without asserting div_start_o.
  - Writeback data: DIV/DIVU → 32'hFFFFFFFF; REM/REMU → rs1_i.
  - Writeback address: rd_i.
  - Writeback occurs in cycle 1.
- Undefined: a zero divisor is issued to the divider like any other operand pair.

## Test plan
- DIV 100 / -7, rd=5:
  - stall_o high from cycle 0 to the ready cycle;
  - one wb_we_o pulse with waddr=5 and wdata=32'hFFFFFFF2;
  - div_start_o low in the ready cycle.
- REMU 32'hFFFFFFFF % 10, rd=9 → wdata=5, waddr=9; operands on div_* are stable throughout BUSY.
- DIVU 1234 / 0:
  - macro on: div_start_o never high, wb_we_o in cycle 1 with wdata=32'hFFFFFFFF;
  - macro off: same data after the divider round trip.
- DIV 7/3, flush_i asserted in cycle 10 of BUSY:
  - div_start_o low that same cycle;
  - no wb_we_o;
  - next request REM 7%3 → wdata=1.
- Back-to-back DIV -17/5 then REM -17%5:
  - wdata 32'hFFFFFFFD, then 32'hFFFFFFFE;
  - exactly two wb_we_o pulses, no duplicate issue.
- Reset asserted mid-BUSY, with flush_i and div_ready_i coincident on a rerun:
  - on reset, all outputs are 0 immediately;
  - on the rerun, no writeback.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue controller between EX and the iterative divider: captures a RV32M divide, holds start, retires one writeback.
// Optional DIV_ZERO_BYPASS_EN: zero-divisor requests skip the divider and write back directly.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic [2:0]  div_op_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic [4:0]  div_waddr_o,
    input  logic [31:0] div_result_i,
    input  logic        div_ready_i,
    input  logic        div_busy_i,
    input  logic [4:0]  div_waddr_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic [31:0] wb_wdata_q, wb_wdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            waddr_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= '0;
            wb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            waddr_q    <= waddr_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        waddr_d    = waddr_q;
        wb_we_d    = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_i && !flush_i && !div_busy_i) begin
`ifdef DIV_ZERO_BYPASS_EN
                    // op_i[1] set means REM/REMU: remainder by zero is the dividend
                    if (rs2_i == '0) begin
                        state_d    = DONE;
                        wb_we_d    = 1'b1;
                        wb_waddr_d = rd_i;
                        wb_wdata_d = op_i[1] ? rs1_i : '1;
                    end else
`endif
                    begin
                        state_d    = BUSY;
                        op_d       = op_i;
                        dividend_d = rs1_i;
                        divisor_d  = rs2_i;
                        waddr_d    = rd_i;
                    end
                end
            end
            BUSY: begin
                // A flush coinciding with ready discards the result
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    state_d    = DONE;
                    wb_we_d    = 1'b1;
                    wb_waddr_d = div_waddr_i;
                    wb_wdata_d = div_result_i;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall_o        = ((state_q == IDLE) && req_i && !flush_i) || (state_q == BUSY);
    assign div_start_o    = (state_q == BUSY) && !div_ready_i && !flush_i;
    assign div_op_o       = op_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_waddr_o    = waddr_q;
    assign wb_we_o        = wb_we_q;
    assign wb_waddr_o     = wb_waddr_q;
    assign wb_wdata_o     = wb_wdata_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench plays the divider with hand-computed results.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, div_start_o, wb_we_o;
    logic [2:0]  div_op_o;
    logic [31:0] div_dividend_o, div_divisor_o, wb_wdata_o;
    logic [4:0]  div_waddr_o, wb_waddr_o;
    logic [31:0] div_result_i = '0;
    logic        div_ready_i = 1'b0;
    logic        div_busy_i = 1'b0;
    logic [4:0]  div_waddr_i = '0;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int p0;

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    div_issue_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .op_i           (op_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rd_i           (rd_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .div_start_o    (div_start_o),
        .div_op_o       (div_op_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_waddr_o    (div_waddr_o),
        .div_result_i   (div_result_i),
        .div_ready_i    (div_ready_i),
        .div_busy_i     (div_busy_i),
        .div_waddr_i    (div_waddr_i),
        .wb_we_o        (wb_we_o),
        .wb_waddr_o     (wb_waddr_o),
        .wb_wdata_o     (wb_wdata_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && wb_we_o) pulses <= pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full issue/complete cycle; ready arrives lat cycles after start rises. Ends in the IDLE cycle after DONE.
    task automatic do_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input int lat);
        req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
        flush_i = 1'b0; div_ready_i = 1'b0; div_busy_i = 1'b0;
        #1;
        chk("req_stall", stall_o, 1);
        chk("req_start", div_start_o, 0);
        tick();
        op_i = op ^ 3'b001; rs1_i = ~a; rs2_i = b + 32'd1; rd_i = ~rd; div_busy_i = 1'b1;
        for (int i = 1; i < lat; i++) begin
            #1;
            chk("busy_start", div_start_o, 1);
            chk("busy_stall", stall_o, 1);
            chk("busy_op", div_op_o, op);
            chk("busy_dividend", div_dividend_o, a);
            chk("busy_divisor", div_divisor_o, b);
            chk("busy_waddr", div_waddr_o, rd);
            chk("busy_wbwe", wb_we_o, 0);
            tick();
        end
        div_ready_i = 1'b1; div_result_i = res; div_waddr_i = rd;
        #1;
        chk("ready_start", div_start_o, 0);
        chk("ready_stall", stall_o, 1);
        chk("ready_dividend", div_dividend_o, a);
        tick();
        div_ready_i = 1'b0; div_busy_i = 1'b0; div_result_i = 32'hDEADBEEF; div_waddr_i = 5'h1F;
        #1;
        chk("done_we", wb_we_o, 1);
        chk("done_waddr", wb_waddr_o, rd);
        chk("done_wdata", wb_wdata_o, res);
        chk("done_stall", stall_o, 0);
        chk("done_start", div_start_o, 0);
        tick();
        req_i = 1'b0;
        #1;
        chk("post_we", wb_we_o, 0);
        chk("post_wdata_hold", wb_wdata_o, res);
        chk("post_start", div_start_o, 0);
    endtask

    initial begin
        #2;
        chk("rst_stall", stall_o, 0);
        chk("rst_start", div_start_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_wdata", wb_wdata_o, 0);
        chk("rst_op", div_op_o, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // DIV 100 / -7 -> -14
        do_div(OP_DIV, 32'd100, 32'hFFFFFFF9, 5'd5, 32'hFFFFFFF2, 4);

        // REMU 0xFFFFFFFF % 10 -> 5
        do_div(OP_REMU, 32'hFFFFFFFF, 32'd10, 5'd9, 32'd5, 6);

        // DIVU 1234 / 0 -> all ones
`ifdef DIV_ZERO_BYPASS_EN
        req_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1234; rs2_i = 32'd0; rd_i = 5'd7; div_busy_i = 1'b0;
        #1;
        chk("z_stall", stall_o, 1);
        chk("z_start0", div_start_o, 0);
        tick();
        #1;
        chk("z_we", wb_we_o, 1);
        chk("z_wdata", wb_wdata_o, 32'hFFFFFFFF);
        chk("z_waddr", wb_waddr_o, 7);
        chk("z_start1", div_start_o, 0);
        chk("z_stall1", stall_o, 0);
        tick();
        req_i = 1'b0;
        #1;
        chk("z_we_off", wb_we_o, 0);
`else
        do_div(OP_DIVU, 32'd1234, 32'd0, 5'd7, 32'hFFFFFFFF, 2);
`endif

        // DIV 7/3 flushed in the tenth BUSY cycle
        p0 = pulses;
        req_i = 1'b1; op_i = OP_DIV; rs1_i = 32'd7; rs2_i = 32'd3; rd_i = 5'd3; div_busy_i = 1'b0;
        tick();
        div_busy_i = 1'b1;
        for (int i = 1; i < 10; i++) begin
            #1;
            chk("fl_busy_start", div_start_o, 1);
            tick();
        end
        flush_i = 1'b1;
        #1;
        chk("fl_start", div_start_o, 0);
        chk("fl_stall", stall_o, 1);
        tick();
        flush_i = 1'b0; div_busy_i = 1'b0; req_i = 1'b0;
        #1;
        chk("fl_after_stall", stall_o, 0);
        chk("fl_after_start", div_start_o, 0);
        chk("fl_after_we", wb_we_o, 0);
        chk("fl_pulses", pulses, p0);

        // Request held off while the divider still reports busy
        req_i = 1'b1; op_i = OP_REM; rs1_i = 32'd7; rs2_i = 32'd3; rd_i = 5'd4; div_busy_i = 1'b1;
        #1;
        chk("hold_stall", stall_o, 1);
        chk("hold_start", div_start_o, 0);
        tick();
        #1;
        chk("hold_start2", div_start_o, 0);
        chk("hold_stall2", stall_o, 1);
        do_div(OP_REM, 32'd7, 32'd3, 5'd4, 32'd1, 3);
        chk("rem_pulses", pulses, p0 + 1);

        // Back-to-back DIV -17/5 then REM -17%5
        p0 = pulses;
        do_div(OP_DIV, 32'hFFFFFFEF, 32'd5, 5'd10, 32'hFFFFFFFD, 5);
        do_div(OP_REM, 32'hFFFFFFEF, 32'd5, 5'd11, 32'hFFFFFFFE, 3);
        tick();
        #1;
        chk("b2b_start", div_start_o, 0);
        chk("b2b_stall", stall_o, 0);
        chk("b2b_pulses", pulses, p0 + 2);

        // Asynchronous reset in the middle of BUSY
        req_i = 1'b1; op_i = OP_DIV; rs1_i = 32'd100; rs2_i = 32'hFFFFFFF9; rd_i = 5'd5;
        tick();
        div_busy_i = 1'b1;
        #1;
        chk("mr_start", div_start_o, 1);
        tick();
        #1;
        rst = 1'b0; req_i = 1'b0; div_busy_i = 1'b0;
        #1;
        chk("mr_stall", stall_o, 0);
        chk("mr_start0", div_start_o, 0);
        chk("mr_op", div_op_o, 0);
        chk("mr_dividend", div_dividend_o, 0);
        chk("mr_divisor", div_divisor_o, 0);
        chk("mr_waddr", div_waddr_o, 0);
        chk("mr_we", wb_we_o, 0);
        chk("mr_wb_waddr", wb_waddr_o, 0);
        chk("mr_wb_wdata", wb_wdata_o, 0);
        tick();
        rst = 1'b1;
        tick();

        // Rerun with flush and ready in the same cycle
        p0 = pulses;
        req_i = 1'b1; op_i = OP_DIV; rs1_i = 32'd9; rs2_i = 32'd2; rd_i = 5'd6;
        tick();
        div_busy_i = 1'b1;
        #1;
        chk("rr_start", div_start_o, 1);
        tick();
        flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 32'd4; div_waddr_i = 5'd6;
        #1;
        chk("rr_fr_start", div_start_o, 0);
        tick();
        flush_i = 1'b0; div_ready_i = 1'b0; div_busy_i = 1'b0; req_i = 1'b0;
        #1;
        chk("rr_we", wb_we_o, 0);
        chk("rr_wdata", wb_wdata_o, 0);
        chk("rr_stall", stall_o, 0);
        tick();
        #1;
        chk("rr_we2", wb_we_o, 0);
        chk("rr_pulses", pulses, p0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
